// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Response entries carry the address, instruction word and error flag together.
package imem_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] ERR_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]        addr;
    logic [INSTR_W-1:0] instr;
    logic               err;
  } imem_resp_t;

  // True when a byte address is misaligned or beyond the memory window.
  // The offset wraps at 32 bits, so addresses below base are out of range too.
  function automatic logic addr_bad(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [32:0] limit);
    logic [31:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || ({1'b0, off} >= limit);
  endfunction

endpackage

// File: rtl/imem_sram.sv
// Word-addressed SRAM, one sync read port and one write port, registered read data.
// One-cycle read latency; a same-cycle read and write of one word returns the old data.
module imem_sram #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Fetch responder: SRAM read tagged with address, in-order, response visible one cycle after accept.
// req_ready comes only from registered occupancy (buffered + in flight), never from resp_ready.
module imem_responder
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RESP_DEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_addr,
  input  logic               flush,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [INSTR_W-1:0] resp_instr,
  output logic [31:0]        resp_addr,
  output logic               resp_err,
  input  logic               prog_we,
  input  logic [31:0]        prog_addr,
  input  logic [31:0]        prog_wdata
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   infl_addr_q;
  logic          infl_err_q;
  imem_resp_t    buf_q [RESP_DEPTH];

  logic [31:0]   req_off, prog_off;
  logic [AW-1:0] req_idx, prog_idx;
  logic          req_err, prog_ok, accept, push, pop;
  logic [31:0]   sram_rdata;
  imem_resp_t    incoming, head;

  assign req_off  = req_addr - BASE_ADDR;
  assign prog_off = prog_addr - BASE_ADDR;
  assign req_idx  = AW'(req_off >> 2);
  assign prog_idx = AW'(prog_off >> 2);
  assign req_err  = addr_bad(req_addr, BASE_ADDR, LIMIT);
  assign prog_ok  = prog_we && !addr_bad(prog_addr, BASE_ADDR, LIMIT);

  // count + inflight never exceeds RESP_DEPTH, so the sum cannot overflow CW bits.
  assign req_ready = !rst && !flush && ((count_q + CW'(inflight_q)) < CW'(RESP_DEPTH));
  assign accept    = req_valid && req_ready;

  imem_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk_i   (clk),
    .re_i    (accept && !req_err),
    .raddr_i (req_idx),
    .rdata_o (sram_rdata),
    .we_i    (prog_ok),
    .waddr_i (prog_idx),
    .wdata_i (prog_wdata)
  );

  always_comb begin
    incoming.addr  = infl_addr_q;
    incoming.instr = infl_err_q ? ERR_INSTR : sram_rdata;
    incoming.err   = infl_err_q;
    // An empty buffer shows the in-flight word straight from the SRAM output.
    head = (count_q != '0) ? buf_q[rd_ptr_q] : incoming;
  end

  always_comb begin
    resp_valid = !rst && ((count_q != '0) || inflight_q);
    resp_instr = '0;
    resp_addr  = '0;
    resp_err   = 1'b0;
    if (resp_valid) begin
      resp_instr = head.instr;
      resp_addr  = head.addr;
      resp_err   = head.err;
    end
  end

  // Every in-flight word is written; a bypassed pop advances the read pointer past it.
  assign push = inflight_q;
  assign pop  = resp_valid && resp_ready;

  always_comb begin
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = 1'b0;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d    = count_q + CW'(push) - CW'(pop);
      inflight_d = accept;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    infl_addr_q <= req_addr;
    infl_err_q  <= req_err;
    if (push) buf_q[wr_ptr_q] <= incoming;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench: queue-based response model compared every cycle, plus directed literal checks.
module tb_imem_responder;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int DW = 16;
  localparam int RD = 2;

  logic        clk = 1'b0;
  logic        rst, req_valid, flush, resp_ready, prog_we;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] req_addr, resp_instr, resp_addr, prog_addr, prog_wdata;

  imem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DW), .RESP_DEPTH(RD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_instr(resp_instr), .resp_addr(resp_addr), .resp_err(resp_err),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } got_t;

  exp_t        q[$];
  got_t        got[$];
  logic [31:0] mm [DW];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic logic bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a - BASE) >= 32'(DW * 4));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Outstanding = accepted and not yet popped; a response is visible from the cycle after its accept.
  always @(posedge clk) begin : model
    exp_t        e;
    logic        rdy, vld;
    logic [31:0] off;
    rdy = !rst && !flush && (q.size() < RD);
    vld = !rst && (q.size() > 0) && (q[0].acc < cyc);
    off = req_addr - BASE;
    e.addr  = req_addr;
    e.err   = bad(req_addr);
    e.instr = 32'h0;
    if (!e.err) e.instr = mm[4'(off >> 2)];
    e.acc   = cyc;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (vld && resp_ready) q.delete(0);
      if (req_valid && rdy) q.push_back(e);
    end
    if (prog_we && !bad(prog_addr)) mm[4'((prog_addr - BASE) >> 2)] = prog_wdata;
    cyc++;
  end

  always @(negedge clk) begin : cmp
    logic rdy, vld;
    got_t g;
    rdy = !rst && !flush && (q.size() < RD);
    vld = !rst && (q.size() > 0) && (q[0].acc < cyc);
    chk("req_ready", 32'(req_ready), 32'(rdy));
    chk("resp_valid", 32'(resp_valid), 32'(vld));
    if (vld) begin
      chk("resp_addr", resp_addr, q[0].addr);
      chk("resp_instr", resp_instr, q[0].instr);
      chk("resp_err", 32'(resp_err), 32'(q[0].err));
    end else begin
      chk("idle_addr", resp_addr, 32'h0);
      chk("idle_instr", resp_instr, 32'h0);
      chk("idle_err", 32'(resp_err), 32'h0);
    end
    if (resp_valid && resp_ready) begin
      g.addr = resp_addr; g.instr = resp_instr; g.err = resp_err;
      got.push_back(g);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic req(input logic [31:0] a);
    req_valid = 1'b1; req_addr = a;
    step();
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic chk_got(input string nm, input int i, input logic [31:0] a,
                         input logic [31:0] ins, input logic er);
    if (got.size() <= i) begin
      n_chk++; n_fail++;
      $display("FAIL %s: response %0d missing, only %0d delivered", nm, i, got.size());
    end else begin
      chk({nm, "_addr"}, got[i].addr, a);
      chk({nm, "_instr"}, got[i].instr, ins);
      chk({nm, "_err"}, 32'(got[i].err), 32'(er));
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0t limit 200000", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0; resp_ready = 1'b1;
    prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'h1);
    chk("reset_resp_valid", 32'(resp_valid), 32'h0);
    chk("reset_resp_instr", resp_instr, 32'h0);
    chk("reset_resp_addr", resp_addr, 32'h0);

    // Preload and back-to-back fetch
    prog(32'h0, 32'h11); prog(32'h4, 32'h22); prog(32'h8, 32'h33); prog(32'hC, 32'h44);
    got.delete();
    req_valid = 1'b1; req_addr = 32'h0;
    step();
    req_addr = 32'h4;
    @(negedge clk);
    chk("t1_bypass_vld", 32'(resp_valid), 32'h1);
    chk("t1_bypass_instr", resp_instr, 32'h11);
    step();
    req_addr = 32'h8; step();
    req_addr = 32'hC; step();
    idle(3);
    chk("t1_count", 32'(got.size()), 32'd4);
    chk_got("t1_r0", 0, 32'h0, 32'h11, 1'b0);
    chk_got("t1_r1", 1, 32'h4, 32'h22, 1'b0);
    chk_got("t1_r2", 2, 32'h8, 32'h33, 1'b0);
    chk_got("t1_r3", 3, 32'hC, 32'h44, 1'b0);

    // Backpressure: only two accepted, third waits for the first pop
    got.delete();
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0; step();
    req_addr = 32'h4; step();
    req_addr = 32'h8; step();
    step();
    @(negedge clk);
    chk("t2_full_ready", 32'(req_ready), 32'h0);
    step();
    resp_ready = 1'b1;
    k = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready) begin k = i; break; end
      step();
    end
    step();
    req_valid = 1'b0;
    chk("t2_accept_delay", 32'(k), 32'd1);
    idle(4);
    chk("t2_count", 32'(got.size()), 32'd3);
    chk_got("t2_r0", 0, 32'h0, 32'h11, 1'b0);
    chk_got("t2_r1", 1, 32'h4, 32'h22, 1'b0);
    chk_got("t2_r2", 2, 32'h8, 32'h33, 1'b0);

    // Misaligned / out-of-range requests and ignored program writes
    got.delete();
    prog(32'h40, 32'hDEAD_0000);
    prog(32'h1, 32'hBEEF_0000);
    req(32'h2); req(32'h40); req(32'h0);
    idle(3);
    chk("t3_count", 32'(got.size()), 32'd3);
    chk_got("t3_misal", 0, 32'h2, 32'h0, 1'b1);
    chk_got("t3_range", 1, 32'h40, 32'h0, 1'b1);
    chk_got("t3_mem", 2, 32'h0, 32'h11, 1'b0);

    // Flush with one buffered and one in flight; a flush-cycle request is refused
    got.delete();
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0; step();
    req_addr = 32'h4; step();
    req_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("t4_post_flush_vld", 32'(resp_valid), 32'h0);
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'hC;
    @(negedge clk);
    chk("t4_flush_ready", 32'(req_ready), 32'h0);
    step();
    flush = 1'b0; req_valid = 1'b0;
    resp_ready = 1'b1;
    idle(2);
    req(32'h8);
    idle(3);
    chk("t4_count", 32'(got.size()), 32'd1);
    chk_got("t4_r0", 0, 32'h8, 32'h33, 1'b0);

    // Read-first on same-cycle program write
    got.delete();
    prog_we = 1'b1; prog_addr = 32'h4; prog_wdata = 32'hAA;
    req_valid = 1'b1; req_addr = 32'h4;
    step();
    prog_we = 1'b0; req_valid = 1'b0;
    idle(2);
    req(32'h4);
    idle(3);
    chk("t5_count", 32'(got.size()), 32'd2);
    chk_got("t5_old", 0, 32'h4, 32'h22, 1'b0);
    chk_got("t5_new", 1, 32'h4, 32'hAA, 1'b0);

    // Reset with two responses pending
    got.delete();
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0; step();
    req_addr = 32'h8; step();
    req_valid = 1'b0; step();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_vld", 32'(resp_valid), 32'h0);
    chk("t6_rst_ready", 32'(req_ready), 32'h0);
    step();
    rst = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    chk("t6_post_rst_ready", 32'(req_ready), 32'h1);
    chk("t6_post_rst_vld", 32'(resp_valid), 32'h0);
    req(32'hC);
    idle(3);
    chk("t6_count", 32'(got.size()), 32'd1);
    chk_got("t6_r0", 0, 32'hC, 32'h44, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
